sdram_line_buffer: RTL and testbench
====================================

# sdram_line_buffer

Single-line, 8-byte read buffer with write-through between the byte-wide DMA engine RAM port (toggle req/ack) and the 64-bit cache port of the SDRAM controller. It converts byte requests into line fills, so sequential REU reads cost one SDRAM access per 8 bytes. The block sits directly downstream of the DMA engine's `ram_*` port and upstream of the SDRAM controller's cache port, which returns 64-bit `q`.

## Interface
Parameters:
- `ram_a_bits`, default 24: byte address width on both sides.

Ports:
- `clk`  in  1  system clock (sysclk). This is the block's only clock.
- `reset`  in  1  reset, asynchronous and active-high.
- `ram_a`  in  ram_a_bits  byte address from the requester.
- `ram_d`  in  8  write data from the requester.
- `ram_we`  in  1  1 = write, 0 = read; sampled with the request.
- `ram_req`  in  1  request toggle; a request is pending while `ram_req != ram_ack`.
- `ram_ack`  out  1  acknowledge toggle.
- `ram_q`  out  8  read data; valid when `ram_ack` toggles.
- `invalidate`  in  1  one-cycle pulse that clears the buffered line (another SDRAM master wrote memory).
- `sdram_a`  out  ram_a_bits  SDRAM byte address.
- `sdram_d`  out  8  SDRAM write byte.
- `sdram_we`  out  1  SDRAM write enable.
- `sdram_req`  out  1  SDRAM request toggle.
- `sdram_ack`  in  1  SDRAM ack toggle; the transaction is complete when `sdram_ack == sdram_req`.
- `sdram_q`  in  64  line data; byte k is at `[8k+7:8k]` for address `{tag, k}`.

## Operation
- State: `line[63:0]`, `tag[ram_a_bits-1:3]`, `valid`, and FSM state in {IDLE, FILL, WRITE}.
- Request detection: in IDLE, `ram_req != ram_ack`. Latch `ram_a`, `ram_d` and `ram_we` on the detect edge.
- Read hit (`valid && ram_a[top:3] == tag`):
  - `ram_q` = `line` byte `ram_a[2:0]`.
  - `ram_ack` toggles.
  - The FSM stays in IDLE.
- Read miss:
  - `sdram_a = {ram_a[top:3], 3'b000}`, `sdram_we = 0`, `sdram_req` toggles.
  - Go to FILL.
- FILL, when `sdram_ack == sdram_req`:
  - `line <= sdram_q` and `tag <= latched a[top:3]`.
  - `valid` is set to 1, unless `invalidate` pulsed during FILL; in that case `valid` stays 0.
  - `ram_q` = byte `a[2:0]` of `sdram_q`, and `ram_ack` toggles.
  - Return to IDLE.
- Write:
  - `sdram_a = ram_a`, `sdram_d = ram_d`, `sdram_we = 1`, `sdram_req` toggles. Go to WRITE.
  - If the write hits the line, that byte of `line` is updated on the same edge. A miss does not allocate.
- WRITE, when `sdram_ack == sdram_req`: toggle `ram_ack`, drop `sdram_we` to 0, return to IDLE. `ram_q` is unchanged on writes.
- `invalidate` behaviour:
  - In any state, it clears `valid` on the next edge.
  - If it coincides with a hit detect, the hit is still served from the old line.
  - If it coincides with a write hit, the byte update is harmless because `valid` ends 0.
- Only one request is outstanding on each side. A new `ram_req` toggle is ignored until `ram_ack` has matched the previous one.
- Tag compare uses the full upper address. There is no aliasing.

## Timing
- Reset values:
  - `ram_ack=0`, `ram_q=0`.
  - `sdram_req=0`, `sdram_we=0`, `sdram_a=0`, `sdram_d=0`.
  - `valid=0`, `line=0`, `tag=0`, state IDLE.
- Read hit: the request toggle is seen before edge N. `ram_q` and `ram_ack` update at edge N, which is 1 cycle after detection.
- Miss and write:
  - `sdram_req` toggles at edge N.
  - The ack match is observed at edge M > N.
  - `ram_ack` toggles at edge M+1, giving latency = SDRAM latency + 2 cycles.
- All outputs are registered. `sdram_a`, `sdram_d` and `sdram_we` are held stable while `sdram_req != sdram_ack`.
- Reset mid-operation: FILL or WRITE is abandoned and all state returns to reset values. Integration contract: the requester shares `reset`, and `reset` is not asserted while an SDRAM transaction is outstanding unless the SDRAM toggle is also reset.
- Reset deassertion is synchronised externally (reset_generator). There is no internal synchroniser.

## Test plan
- Read miss then hits:
  - Stimulus: SDRAM model holds line 0x001230 = 0x8877665544332211. Read 0x001230, then reads 0x001231 and 0x001237.
  - Required: the first read issues one SDRAM read at 0x001230 and returns 0x11.
  - Required: the next two reads return 0x22 and 0x88 in 1 cycle each, with no `sdram_req` toggles.
- Write-through hit: with the line above valid, write 0xAA to 0x001233, then read 0x001233.
  - Required: SDRAM write at 0x001233 with d=0xAA and we=1.
  - Required: the read returns 0xAA with no SDRAM read.
- Write miss no-allocate: write 0x55 to 0x004000, then read 0x001230.
  - Required: the read still hits (0x11) without an SDRAM access.
- Invalidate during fill: pulse `invalidate` while FILL is awaiting ack.
  - Required: the requester still receives the correct byte.
  - Required: a following read of the same line issues a new SDRAM read.
- Toggle protocol:
  - Stimulus: ack delays of 0, 1 and 17 cycles; `ram_req` toggled both 0→1 and 1→0.
  - Required: exactly one SDRAM transaction per request.
  - Required: `sdram_a`, `sdram_d` and `sdram_we` stay stable while the request is pending.
- Reset mid-FILL: assert `reset` during FILL.
  - Required: all outputs return to reset values asynchronously.
  - Required: `valid=0`, and the next read misses.

Source files
------------

// File: rtl/sdram_line_buffer.sv
// sdram_line_buffer: one-line (8-byte) read buffer with write-through, placed between the
// byte-wide DMA RAM port (toggle req/ack) and the 64-bit SDRAM controller cache port.
// Sequential byte reads within one line cost a single SDRAM access.
//
// Ports:
//   clk, reset              system clock, asynchronous active-high reset
//   ram_a/ram_d/ram_we      requester byte address, write data, write flag
//   ram_req/ram_ack         requester toggle handshake (pending while they differ)
//   ram_q                   read data, valid when ram_ack toggles
//   invalidate              one-cycle pulse, drops the buffered line
//   sdram_a/sdram_d/sdram_we  SDRAM byte address, write byte, write enable
//   sdram_req/sdram_ack     SDRAM toggle handshake (done when they match)
//   sdram_q                 64-bit line data, byte k at [8k+7:8k]
module sdram_line_buffer #(
    parameter int unsigned ram_a_bits = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ram_a_bits-1:0] ram_a,
    input  logic [7:0]            ram_d,
    input  logic                  ram_we,
    input  logic                  ram_req,
    output logic                  ram_ack,
    output logic [7:0]            ram_q,
    input  logic                  invalidate,
    output logic [ram_a_bits-1:0] sdram_a,
    output logic [7:0]            sdram_d,
    output logic                  sdram_we,
    output logic                  sdram_req,
    input  logic                  sdram_ack,
    input  logic [63:0]           sdram_q
);

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    state_t                  state;
    logic [63:0]             line;
    logic [ram_a_bits-1:3]   tag;
    logic                    valid;
    logic [ram_a_bits-1:0]   a_lat;
    logic                    ack_r;       // registered sdram_ack; completion acts one edge later
    logic                    inval_seen;  // invalidate pulsed while the fill was in flight

    logic pending;
    logic hit;

    assign pending = (ram_req != ram_ack);
    assign hit     = valid && (ram_a[ram_a_bits-1:3] == tag);

    function automatic logic [7:0] pick(input logic [63:0] l, input logic [2:0] k);
        return l[{k, 3'b000} +: 8];
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            line       <= '0;
            tag        <= '0;
            valid      <= 1'b0;
            a_lat      <= '0;
            ack_r      <= 1'b0;
            inval_seen <= 1'b0;
            ram_ack    <= 1'b0;
            ram_q      <= '0;
            sdram_a    <= '0;
            sdram_d    <= '0;
            sdram_we   <= 1'b0;
            sdram_req  <= 1'b0;
        end else begin
            ack_r <= sdram_ack;
            if (invalidate) valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (pending) begin
                        a_lat <= ram_a;
                        if (ram_we) begin
                            sdram_a   <= ram_a;
                            sdram_d   <= ram_d;
                            sdram_we  <= 1'b1;
                            sdram_req <= ~sdram_req;
                            // Keep the line coherent; a miss does not allocate.
                            if (hit) line[{ram_a[2:0], 3'b000} +: 8] <= ram_d;
                            state     <= WRITE;
                        end else if (hit) begin
                            // Served from the current line even if invalidate coincides.
                            ram_q   <= pick(line, ram_a[2:0]);
                            ram_ack <= ~ram_ack;
                        end else begin
                            sdram_a    <= {ram_a[ram_a_bits-1:3], 3'b000};
                            sdram_we   <= 1'b0;
                            sdram_req  <= ~sdram_req;
                            inval_seen <= 1'b0;
                            state      <= FILL;
                        end
                    end
                end

                FILL: begin
                    if (invalidate) inval_seen <= 1'b1;
                    if (ack_r == sdram_req) begin
                        line    <= sdram_q;
                        tag     <= a_lat[ram_a_bits-1:3];
                        // Data fetched before a foreign write may be stale: deliver, don't keep.
                        valid   <= !(inval_seen || invalidate);
                        ram_q   <= pick(sdram_q, a_lat[2:0]);
                        ram_ack <= ~ram_ack;
                        state   <= IDLE;
                    end
                end

                WRITE: begin
                    if (ack_r == sdram_req) begin
                        ram_ack  <= ~ram_ack;
                        sdram_we <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_line_buffer.sv
// Self-checking bench for sdram_line_buffer: requester tasks push expected read bytes into a
// scoreboard queue and compare on ram_ack; a behavioural SDRAM model with programmable ack
// delay holds line memory and records every transaction.
module tb_sdram_line_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] ram_a;
    logic [7:0]  ram_d;
    logic        ram_we;
    logic        ram_req;
    logic        ram_ack;
    logic [7:0]  ram_q;
    logic        invalidate;
    logic [23:0] sdram_a;
    logic [7:0]  sdram_d;
    logic        sdram_we;
    logic        sdram_req;
    logic        sdram_ack;
    logic [63:0] sdram_q;

    int n_vec = 0;
    int n_err = 0;

    // SDRAM model state
    int          sd_delay = 0;
    int          n_txn = 0;
    logic [23:0] last_a;
    logic [7:0]  last_d;
    logic        last_we;
    logic [63:0] mem [logic [23:0]];

    logic [7:0]  exp_q [$];
    logic [7:0]  last_rd = 8'h00;

    always #5 clk = ~clk;

    sdram_line_buffer #(.ram_a_bits(24)) dut (
        .clk        (clk),
        .reset      (reset),
        .ram_a      (ram_a),
        .ram_d      (ram_d),
        .ram_we     (ram_we),
        .ram_req    (ram_req),
        .ram_ack    (ram_ack),
        .ram_q      (ram_q),
        .invalidate (invalidate),
        .sdram_a    (sdram_a),
        .sdram_d    (sdram_d),
        .sdram_we   (sdram_we),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_q    (sdram_q)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] mem_line(input logic [23:0] la);
        if (mem.exists(la)) return mem[la];
        return 64'hF0E1D2C3B4A59687 ^ {8{la[10:3]}};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [23:0] a);
        logic [63:0] l;
        l = mem_line({a[23:3], 3'b000});
        return l[8*a[2:0] +: 8];
    endfunction

    // SDRAM model: one transaction per req toggle, ack after sd_delay extra edges.
    initial begin
        logic [23:0] ca;
        logic [7:0]  cd;
        logic        cw;
        logic [63:0] tmp;
        logic        aborted;
        sdram_ack = 1'b0;
        sdram_q   = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                sdram_ack = 1'b0;
            end else if (sdram_req != sdram_ack) begin
                ca = sdram_a;
                cd = sdram_d;
                cw = sdram_we;
                n_txn++;
                last_a  = ca;
                last_d  = cd;
                last_we = cw;
                aborted = 1'b0;
                for (int i = 0; i < sd_delay; i++) begin
                    @(posedge clk);
                    #2;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (aborted) begin
                    sdram_ack = 1'b0;
                end else begin
                    check("sd_stable", {sdram_a, sdram_d, sdram_we}, {ca, cd, cw});
                    if (cw) begin
                        tmp = mem_line({ca[23:3], 3'b000});
                        tmp[8*ca[2:0] +: 8] = cd;
                        mem[{ca[23:3], 3'b000}] = tmp;
                    end else begin
                        sdram_q = mem_line({ca[23:3], 3'b000});
                    end
                    sdram_ack = sdram_req;
                end
            end
        end
    end

    task automatic do_read(input logic [23:0] addr, input bit exp_miss, input int inv_at);
        int          t0;
        int          cycles;
        logic [7:0]  e;
        e = ref_byte(addr);
        exp_q.push_back(e);
        t0 = n_txn;
        @(posedge clk);
        #1;
        ram_a      = addr;
        ram_we     = 1'b0;
        ram_req    = ~ram_req;
        invalidate = (inv_at == 0);
        cycles     = 0;
        while (ram_ack != ram_req && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            invalidate = (cycles == inv_at);
        end
        invalidate = 1'b0;
        check("rd_done", ram_ack, ram_req);
        e = exp_q.pop_front();
        last_rd = e;
        check("rd_q", ram_q, e);
        check("rd_lat", cycles, exp_miss ? sd_delay + 3 : 1);
        check("rd_txns", n_txn - t0, exp_miss ? 1 : 0);
        if (exp_miss) begin
            check("rd_sd_a", last_a, {addr[23:3], 3'b000});
            check("rd_sd_we", last_we, 1'b0);
        end
    endtask

    task automatic do_write(input logic [23:0] addr, input logic [7:0] d);
        int t0;
        int cycles;
        t0 = n_txn;
        @(posedge clk);
        #1;
        ram_a   = addr;
        ram_d   = d;
        ram_we  = 1'b1;
        ram_req = ~ram_req;
        cycles  = 0;
        while (ram_ack != ram_req && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        ram_we = 1'b0;
        check("wr_done", ram_ack, ram_req);
        check("wr_q_hold", ram_q, last_rd);
        check("wr_lat", cycles, sd_delay + 3);
        check("wr_txns", n_txn - t0, 1);
        check("wr_sd_a", last_a, addr);
        check("wr_sd_d", last_d, d);
        check("wr_sd_we", last_we, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        mem[24'h001230] = 64'h8877665544332211;
        reset      = 1'b1;
        ram_a      = '0;
        ram_d      = '0;
        ram_we     = 1'b0;
        ram_req    = 1'b0;
        invalidate = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ram_ack", ram_ack, 1'b0);
        check("rst_ram_q", ram_q, 8'h00);
        check("rst_sdram_req", sdram_req, 1'b0);
        check("rst_sdram_we", sdram_we, 1'b0);
        check("rst_sdram_a", sdram_a, 24'h0);
        check("rst_sdram_d", sdram_d, 8'h00);
        reset = 1'b0;

        // Miss then hits, zero-delay SDRAM
        sd_delay = 0;
        do_read(24'h001230, 1'b1, -1);
        do_read(24'h001231, 1'b0, -1);
        do_read(24'h001237, 1'b0, -1);

        // Write-through hit, one-cycle SDRAM
        sd_delay = 1;
        do_write(24'h001233, 8'hAA);
        do_read(24'h001233, 1'b0, -1);

        // Write miss does not allocate, slow SDRAM
        sd_delay = 17;
        do_write(24'h004000, 8'h55);
        do_read(24'h001230, 1'b0, -1);

        // Invalidate during fill: byte delivered, line not kept
        sd_delay = 5;
        do_read(24'h002008, 1'b1, 3);
        sd_delay = 0;
        do_read(24'h00200A, 1'b1, -1);
        do_read(24'h00200B, 1'b0, -1);
        // Invalidate coincident with a hit: served from old line, then gone
        do_read(24'h00200C, 1'b0, 0);
        do_read(24'h00200D, 1'b1, -1);

        // Reset in the middle of a fill
        sd_delay = 17;
        @(posedge clk);
        #1;
        ram_a   = 24'h001230;
        ram_we  = 1'b0;
        ram_req = ~ram_req;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_ram_ack", ram_ack, 1'b0);
        check("mid_rst_ram_q", ram_q, 8'h00);
        check("mid_rst_sdram_req", sdram_req, 1'b0);
        check("mid_rst_sdram_we", sdram_we, 1'b0);
        check("mid_rst_sdram_a", sdram_a, 24'h0);
        check("mid_rst_sdram_d", sdram_d, 8'h00);
        ram_req = 1'b0;
        last_rd = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        sd_delay = 0;
        do_read(24'h001230, 1'b1, -1);
        do_read(24'h001233, 1'b0, -1);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
